// File: rtl/int_ctrl.sv
// int_ctrl: four-source prioritised interrupt controller with edge-latched pending bits and a vector output.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   irq[3:0]          - level request lines; a rising edge latches pending; bit 0 has the highest priority
//   mask_we, mask_d   - mask load strobe and value (1 = source masked)
//   ie_we, ie_d       - global enable load strobe and value
//   reti              - return-from-interrupt strobe, honoured only while servicing
//   int_save/int_load - one-cycle pulses for PC jump-and-save and for PC restore
//   int_v, active_id  - vector address and index of the source being entered
//   busy, pending     - service in progress; latched pending requests
module int_ctrl #(
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter logic [7:0] VEC_STRIDE = 8'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq,
  input  logic       mask_we,
  input  logic [3:0] mask_d,
  input  logic       ie_we,
  input  logic       ie_d,
  input  logic       reti,
  output logic       int_save,
  output logic       int_load,
  output logic [7:0] int_v,
  output logic       busy,
  output logic [1:0] active_id,
  output logic [3:0] pending
);
  typedef enum logic [1:0] {IDLE, SAVE, SERVICE, RESTORE} state_t;
  state_t state, state_nx;
  logic [3:0] irq_q, mask, rise, elig, clr;
  logic ie, armed, entry;
  logic [1:0] winner;
  // armed stays low for the first cycle after reset so a line already high at release is not seen as an edge
  assign rise = armed ? irq & ~irq_q : 4'h0;
  assign elig = ie ? pending & ~mask : 4'h0;
  assign winner = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
  assign entry = (state == IDLE) && |elig;
  assign clr = entry ? 4'b0001 << winner : 4'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_q     <= 4'h0;
      armed     <= 1'b0;
      pending   <= 4'h0;
      mask      <= 4'hF;
      ie        <= 1'b0;
      int_v     <= 8'h00;
      active_id <= 2'd0;
    end else begin
      state   <= state_nx;
      irq_q   <= irq;
      armed   <= 1'b1;
      // a fresh edge on the winner overrides its clear
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_d;
      if (ie_we) ie <= ie_d;
      if (entry) begin
        active_id <= winner;
        int_v     <= VEC_BASE + {6'b0, winner} * VEC_STRIDE;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = entry ? SAVE : IDLE;
      SAVE:    state_nx = SERVICE;
      SERVICE: state_nx = reti ? RESTORE : SERVICE;
      default: state_nx = IDLE;
    endcase
  end
  // pulses and busy are decodes of the state register, so they carry no input-to-output path
  always_comb begin
    int_save = state == SAVE;
    int_load = state == RESTORE;
    busy     = state != IDLE;
  end
endmodule
